// File: rtl/axi_mem_pkg.sv
// Shared types, counter widths and the address-to-word-index helper for the
// AXI memory responder.
package axi_mem_pkg;

    localparam int unsigned BEAT_CNT_WIDTH  = 4;
    localparam int unsigned LAT_CNT_WIDTH   = 4;
    localparam int unsigned MAX_ADDR_WIDTH  = 64;
    localparam int unsigned MAX_DEPTH_WIDTH = 32;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_BURST
    } r_state_t;

    // Byte address -> word index; byte-offset bits dropped, bits above the
    // memory depth masked off so the array aliases through the address space.
    function automatic logic [MAX_DEPTH_WIDTH-1:0] word_index(
        input logic [MAX_ADDR_WIDTH-1:0] addr,
        input int unsigned               depth_width
    );
        logic [MAX_DEPTH_WIDTH-1:0] idx;
        idx = MAX_DEPTH_WIDTH'(addr >> 2);
        return idx & ~({MAX_DEPTH_WIDTH{1'b1}} << depth_width);
    endfunction

endpackage

// File: rtl/axi_mem_responder_if.sv
// AXI3-style single-port bus bundle between the core's arbiter (master) and
// the memory responder (slave).
interface axi_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [3:0]            AWID;
    logic [3:0]            AWLEN;
    logic [ADDR_WIDTH-1:0] AWADDR;

    logic                  WVALID;
    logic                  WREADY;
    logic                  WLAST;
    logic [3:0]            WID;
    logic [DATA_WIDTH-1:0] WDATA;

    logic                  BVALID;
    logic                  BREADY;
    logic [3:0]            BID;

    logic                  ARVALID;
    logic                  ARREADY;
    logic [3:0]            ARID;
    logic [3:0]            ARLEN;
    logic [ADDR_WIDTH-1:0] ARADDR;

    logic                  RVALID;
    logic                  RREADY;
    logic                  RLAST;
    logic [3:0]            RID;
    logic [DATA_WIDTH-1:0] RDATA;

    modport master (
        output AWVALID, AWID, AWLEN, AWADDR,
        output WVALID, WLAST, WID, WDATA,
        output BREADY,
        output ARVALID, ARID, ARLEN, ARADDR,
        output RREADY,
        input  AWREADY, WREADY, BVALID, BID,
        input  ARREADY, RVALID, RLAST, RID, RDATA
    );

    modport slave (
        input  AWVALID, AWID, AWLEN, AWADDR,
        input  WVALID, WLAST, WID, WDATA,
        input  BREADY,
        input  ARVALID, ARID, ARLEN, ARADDR,
        input  RREADY,
        output AWREADY, WREADY, BVALID, BID,
        output ARREADY, RVALID, RLAST, RID, RDATA
    );
endinterface

// File: rtl/axi_mem_array.sv
// Word array: one synchronous write port, one combinational read port.
// Contents are never reset.
module axi_mem_array #(
  parameter int unsigned DEPTH_WIDTH = 14,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter string       INIT_FILE   = ""
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [DEPTH_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [DEPTH_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_WIDTH];

  // Write port: commit on the clock edge of an accepted beat.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI3-style memory responder: independent write and read FSMs sharing one
// word array, with programmable read latency and a sticky protocol-error flag.
module axi_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 26,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH_WIDTH  = 14,
    parameter int unsigned READ_LATENCY = 4,
    parameter string       INIT_FILE    = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_mem_responder_if.slave  bus,
    output logic                protocol_error
);
    localparam logic [DEPTH_WIDTH-1:0]    IDX_ONE = DEPTH_WIDTH'(1);
    localparam logic [BEAT_CNT_WIDTH-1:0] CNT_ONE = BEAT_CNT_WIDTH'(1);
    localparam logic [LAT_CNT_WIDTH-1:0]  LAT_ONE = LAT_CNT_WIDTH'(1);
    localparam logic [LAT_CNT_WIDTH-1:0]  LAT_LOAD = LAT_CNT_WIDTH'(READ_LATENCY - 1);

    // Write channel state
    w_state_t                  w_state_q, w_state_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [3:0]                awid_q, awid_d;
    logic [BEAT_CNT_WIDTH-1:0] awlen_q, awlen_d;
    logic [BEAT_CNT_WIDTH-1:0] w_cnt_q, w_cnt_d;
    logic [DEPTH_WIDTH-1:0]    w_idx_q, w_idx_d;
    logic                      perr_q, perr_d;
    logic                      w_last_beat;

    // Read channel state
    r_state_t                  r_state_q, r_state_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic                      rlast_q, rlast_d;
    logic [3:0]                arid_q, arid_d;
    logic [BEAT_CNT_WIDTH-1:0] arlen_q, arlen_d;
    logic [BEAT_CNT_WIDTH-1:0] r_cnt_q, r_cnt_d;
    logic [DEPTH_WIDTH-1:0]    r_idx_q, r_idx_d;
    logic [LAT_CNT_WIDTH-1:0]  lat_q, lat_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      r_last_beat;
    logic                      r_advance;

    // Array ports
    logic                      mem_we;
    logic [DEPTH_WIDTH-1:0]    mem_raddr;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    axi_mem_array #(
        .DEPTH_WIDTH (DEPTH_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (w_idx_q),
        .wdata (bus.WDATA),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign w_last_beat = (w_cnt_q == awlen_q);
    assign r_last_beat = (r_cnt_q == arlen_q);

    // Read-port address: look one word ahead on a non-final read handshake so
    // the next beat is registered on the same edge (back-to-back beats).
    assign r_advance = (r_state_q == R_BURST) && rvalid_q && bus.RREADY && !r_last_beat;
    assign mem_raddr = r_advance ? (r_idx_q + IDX_ONE) : r_idx_q;

    // Write FSM next-state, burst bookkeeping and protocol checking.
    always_comb begin
        w_state_d = w_state_q;
        awid_d    = awid_q;
        awlen_d   = awlen_q;
        w_cnt_d   = w_cnt_q;
        w_idx_d   = w_idx_q;
        perr_d    = perr_q;
        mem_we    = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (awready_q && bus.AWVALID) begin
                    awid_d    = bus.AWID;
                    awlen_d   = bus.AWLEN;
                    w_idx_d   = DEPTH_WIDTH'(word_index(MAX_ADDR_WIDTH'(bus.AWADDR), DEPTH_WIDTH));
                    w_cnt_d   = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wready_q && bus.WVALID) begin
                    mem_we  = 1'b1;
                    w_idx_d = w_idx_q + IDX_ONE;
                    w_cnt_d = w_cnt_q + CNT_ONE;
                    if ((bus.WLAST != w_last_beat) || (bus.WID != awid_q)) begin
                        perr_d = 1'b1;
                    end
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && bus.BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Write channel registers; handshake outputs are registered so they sit
    // low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            awid_q    <= '0;
            awlen_q   <= '0;
            w_cnt_q   <= '0;
            w_idx_q   <= '0;
            perr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            awid_q    <= awid_d;
            awlen_q   <= awlen_d;
            w_cnt_q   <= w_cnt_d;
            w_idx_q   <= w_idx_d;
            perr_q    <= perr_d;
        end
    end

    // Read FSM next-state: latency countdown, then beat delivery.
    always_comb begin
        r_state_d = r_state_q;
        arid_d    = arid_q;
        arlen_d   = arlen_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        lat_d     = lat_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;

        case (r_state_q)
            R_IDLE: begin
                if (arready_q && bus.ARVALID) begin
                    arid_d    = bus.ARID;
                    arlen_d   = bus.ARLEN;
                    r_idx_d   = DEPTH_WIDTH'(word_index(MAX_ADDR_WIDTH'(bus.ARADDR), DEPTH_WIDTH));
                    r_cnt_d   = '0;
                    lat_d     = LAT_LOAD;
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (lat_q == '0) begin
                    rdata_d   = mem_rdata;
                    rvalid_d  = 1'b1;
                    rlast_d   = r_last_beat;
                    r_state_d = R_BURST;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            R_BURST: begin
                if (rvalid_q && bus.RREADY) begin
                    if (r_last_beat) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_idx_q + IDX_ONE;
                        r_cnt_d = r_cnt_q + CNT_ONE;
                        rdata_d = mem_rdata;
                        rlast_d = ((r_cnt_q + CNT_ONE) == arlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        arready_d = (r_state_d == R_IDLE);
    end

    // Read channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arid_q    <= '0;
            arlen_q   <= '0;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            lat_q     <= '0;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            arid_q    <= arid_d;
            arlen_q   <= arlen_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            lat_q     <= lat_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.AWREADY    = awready_q;
    assign bus.WREADY     = wready_q;
    assign bus.BVALID     = bvalid_q;
    assign bus.BID        = awid_q;
    assign bus.ARREADY    = arready_q;
    assign bus.RVALID     = rvalid_q;
    assign bus.RLAST      = rlast_q;
    assign bus.RID        = arid_q;
    assign bus.RDATA      = rdata_q;
    assign protocol_error = perr_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed testbench for axi_mem_responder.
module tb_axi_mem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic perr;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    axi_mem_responder_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus ();

    axi_mem_responder #(
        .ADDR_WIDTH   (26),
        .DATA_WIDTH   (32),
        .DEPTH_WIDTH  (14),
        .READ_LATENCY (4),
        .INIT_FILE    ("")
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .protocol_error (perr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [25:0] addr, input logic [3:0] len, input logic [3:0] id);
        int n = 0;
        bus.AWVALID = 1'b1; bus.AWADDR = addr; bus.AWLEN = len; bus.AWID = id;
        while (!bus.AWREADY && n < 50) begin tick(); n++; end
        if (!bus.AWREADY) check("aw_timeout", 32'd0, 32'd1);
        tick();
        bus.AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic last, input logic [3:0] id);
        int n = 0;
        bus.WVALID = 1'b1; bus.WDATA = data; bus.WLAST = last; bus.WID = id;
        while (!bus.WREADY && n < 50) begin tick(); n++; end
        if (!bus.WREADY) check("w_timeout", 32'd0, 32'd1);
        tick();
        bus.WVALID = 1'b0;
    endtask

    task automatic b_wait(input logic [3:0] id);
        int n = 0;
        bus.BREADY = 1'b1;
        while (!bus.BVALID && n < 50) begin tick(); n++; end
        check("bvalid", 32'(bus.BVALID), 32'd1);
        check("bid", 32'(bus.BID), 32'(id));
        tick();
        bus.BREADY = 1'b0;
    endtask

    task automatic ar_send(input logic [25:0] addr, input logic [3:0] len, input logic [3:0] id,
                           output int hs);
        int n = 0;
        bus.ARVALID = 1'b1; bus.ARADDR = addr; bus.ARLEN = len; bus.ARID = id;
        while (!bus.ARREADY && n < 50) begin tick(); n++; end
        if (!bus.ARREADY) check("ar_timeout", 32'd0, 32'd1);
        tick();
        hs = cyc;
        bus.ARVALID = 1'b0;
    endtask

    task automatic wait_r(input string tag);
        int n = 0;
        while (!bus.RVALID && n < 50) begin tick(); n++; end
        check(tag, 32'(bus.RVALID), 32'd1);
    endtask

    task automatic read_single(input logic [25:0] addr, input logic [3:0] id,
                               input logic [31:0] exp, input string tag);
        int hs;
        ar_send(addr, 4'd0, id, hs);
        bus.RREADY = 1'b1;
        wait_r({tag, "_rvalid"});
        check({tag, "_rdata"}, bus.RDATA, exp);
        check({tag, "_rlast"}, 32'(bus.RLAST), 32'd1);
        check({tag, "_rid"}, 32'(bus.RID), 32'(id));
        tick();
        bus.RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] bdata [4];
        int hs;
        int k;
        bdata[0] = 32'h11; bdata[1] = 32'h22; bdata[2] = 32'h33; bdata[3] = 32'h44;

        bus.AWVALID = 0; bus.AWID = 0; bus.AWLEN = 0; bus.AWADDR = 0;
        bus.WVALID = 0; bus.WLAST = 0; bus.WID = 0; bus.WDATA = 0;
        bus.BREADY = 0; bus.ARVALID = 0; bus.ARID = 0; bus.ARLEN = 0;
        bus.ARADDR = 0; bus.RREADY = 0;

        // Reset state
        tick(); tick();
        check("rst_awready", 32'(bus.AWREADY), 32'd0);
        check("rst_arready", 32'(bus.ARREADY), 32'd0);
        check("rst_wready", 32'(bus.WREADY), 32'd0);
        check("rst_bvalid", 32'(bus.BVALID), 32'd0);
        check("rst_rvalid", 32'(bus.RVALID), 32'd0);
        check("rst_perr", 32'(perr), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_awready", 32'(bus.AWREADY), 32'd1);
        check("idle_arready", 32'(bus.ARREADY), 32'd1);

        // Single write then read, latency exactly 4
        aw_send(26'h100, 4'd0, 4'd3);
        check("aw_wready", 32'(bus.WREADY), 32'd1);
        check("aw_awready_low", 32'(bus.AWREADY), 32'd0);
        w_send(32'hDEADBEEF, 1'b1, 4'd3);
        b_wait(4'd3);
        check("single_perr", 32'(perr), 32'd0);
        ar_send(26'h100, 4'd0, 4'd5, hs);
        bus.RREADY = 1'b1;
        wait_r("lat_rvalid");
        check("lat_cycles", 32'(cyc - hs), 32'd4);
        check("single_rdata", bus.RDATA, 32'hDEADBEEF);
        check("single_rlast", 32'(bus.RLAST), 32'd1);
        check("single_rid", 32'(bus.RID), 32'd5);
        tick();
        bus.RREADY = 1'b0;
        check("single_rvalid_drop", 32'(bus.RVALID), 32'd0);

        // 4-beat burst write then back-to-back read
        aw_send(26'h200, 4'd3, 4'd1);
        for (int i = 0; i < 4; i++) w_send(bdata[i], (i == 3), 4'd1);
        b_wait(4'd1);
        ar_send(26'h200, 4'd3, 4'd2, hs);
        bus.RREADY = 1'b1;
        wait_r("b2b_first");
        for (int i = 0; i < 4; i++) begin
            check("b2b_rvalid", 32'(bus.RVALID), 32'd1);
            check("b2b_rdata", bus.RDATA, bdata[i]);
            check("b2b_rlast", 32'(bus.RLAST), 32'(i == 3));
            tick();
        end
        bus.RREADY = 1'b0;
        check("b2b_end", 32'(bus.RVALID), 32'd0);

        // Read backpressure, RREADY pattern 1,0,0,1 repeating
        ar_send(26'h200, 4'd3, 4'd7, hs);
        wait_r("bp_first");
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            bus.RREADY = ((c % 4) == 0) || ((c % 4) == 3);
            check("bp_rvalid", 32'(bus.RVALID), 32'd1);
            check("bp_rdata", bus.RDATA, bdata[k]);
            check("bp_rlast", 32'(bus.RLAST), 32'(k == 3));
            check("bp_rid", 32'(bus.RID), 32'd7);
            if (bus.RREADY) k++;
            tick();
        end
        bus.RREADY = 1'b0;
        check("bp_beats", 32'(k), 32'd4);
        check("bp_end", 32'(bus.RVALID), 32'd0);

        // Write response backpressure
        aw_send(26'h104, 4'd0, 4'd9);
        w_send(32'h55, 1'b1, 4'd9);
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", 32'(bus.BVALID), 32'd1);
            check("bp_bid", 32'(bus.BID), 32'd9);
            tick();
        end
        b_wait(4'd9);
        check("bp_bvalid_drop", 32'(bus.BVALID), 32'd0);
        read_single(26'h104, 4'd0, 32'h55, "bp_wdata");

        // Index wrap and aliasing
        aw_send(26'hFFFC, 4'd1, 4'd4);
        w_send(32'hA1, 1'b0, 4'd4);
        w_send(32'hA2, 1'b1, 4'd4);
        b_wait(4'd4);
        check("wrap_perr", 32'(perr), 32'd0);
        read_single(26'h0FFFC, 4'd1, 32'hA1, "wrap_top");
        read_single(26'h00000, 4'd2, 32'hA2, "wrap_zero");
        read_single(26'h10000, 4'd3, 32'hA2, "alias");

        // Protocol error: early WLAST, completion still by count
        aw_send(26'h400, 4'd1, 4'd6);
        w_send(32'hB1, 1'b1, 4'd6);
        check("perr_set", 32'(perr), 32'd1);
        check("perr_wready", 32'(bus.WREADY), 32'd1);
        check("perr_no_b", 32'(bus.BVALID), 32'd0);
        w_send(32'hB2, 1'b0, 4'd6);
        b_wait(4'd6);
        check("perr_sticky", 32'(perr), 32'd1);
        read_single(26'h404, 4'd1, 32'hB2, "perr_beat1");

        // Same-cycle read and write of one word returns the old value
        aw_send(26'h300, 4'd0, 4'd2);
        w_send(32'hAA, 1'b1, 4'd2);
        b_wait(4'd2);
        aw_send(26'h300, 4'd0, 4'd2);
        ar_send(26'h300, 4'd0, 4'd1, hs);
        tick(); tick(); tick();
        check("coll_pre_rvalid", 32'(bus.RVALID), 32'd0);
        bus.WVALID = 1'b1; bus.WDATA = 32'hBB; bus.WLAST = 1'b1; bus.WID = 4'd2;
        tick();
        bus.WVALID = 1'b0;
        check("coll_rvalid", 32'(bus.RVALID), 32'd1);
        check("coll_cycles", 32'(cyc - hs), 32'd4);
        check("coll_old", bus.RDATA, 32'hAA);
        bus.RREADY = 1'b1;
        tick();
        bus.RREADY = 1'b0;
        b_wait(4'd2);
        read_single(26'h300, 4'd4, 32'hBB, "coll_new");

        // Reset in the middle of a read burst with a write pending
        aw_send(26'h500, 4'd0, 4'd8);
        ar_send(26'h200, 4'd3, 4'd3, hs);
        bus.RREADY = 1'b1;
        wait_r("mid_first");
        tick();
        check("mid_rvalid", 32'(bus.RVALID), 32'd1);
        check("mid_wready", 32'(bus.WREADY), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_rvalid", 32'(bus.RVALID), 32'd0);
        check("mrst_arready", 32'(bus.ARREADY), 32'd0);
        check("mrst_awready", 32'(bus.AWREADY), 32'd0);
        check("mrst_wready", 32'(bus.WREADY), 32'd0);
        check("mrst_bvalid", 32'(bus.BVALID), 32'd0);
        check("mrst_perr", 32'(perr), 32'd0);
        bus.RREADY = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        check("post_arready", 32'(bus.ARREADY), 32'd1);
        read_single(26'h200, 4'd5, 32'h11, "post_rst");
        read_single(26'h100, 4'd6, 32'hDEADBEEF, "post_rst2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
